// File: rtl/route_tcam_mc.sv
// route_tcam_mc: ternary route table that streams every matching payload for each fired PacketID
module route_tcam_mc #(
  parameter int ID_Width     = 4,
  parameter int Bits         = 8,
  parameter int Words        = 16,
  parameter int AddressSize  = 4,
  parameter int Weight_Width = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [2:0]              mode,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [AddressSize-1:0]  addr,
  input  logic [Bits-1:0]         key_in,
  input  logic [Bits-1:0]         care_in,
  input  logic                    vld_in,
  input  logic [ID_Width-1:0]     dst_in,
  input  logic [Weight_Width-1:0] weight_in,
  input  logic                    pkt_valid,
  output logic                    pkt_ready,
  input  logic [ID_Width-1:0]     pkt_id,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [ID_Width-1:0]     out_dst,
  output logic [Weight_Width-1:0] out_weight,
  output logic [AddressSize-1:0]  out_addr,
  output logic                    rd_valid,
  output logic [Bits-1:0]         rd_key,
  output logic [Bits-1:0]         rd_care,
  output logic                    rd_vld,
  output logic                    hit,
  output logic [Words-1:0]        hitline,
  output logic [AddressSize-1:0]  hit_addr
);
  typedef enum logic [1:0] {IDLE, SEARCH, STREAM} state_t;
  localparam logic [Bits-1:0] ID_MASK = {{ID_Width{1'b1}}, {(Bits-ID_Width){1'b0}}};
  state_t state, state_nx;
  logic up, idle, fire, cmd_go, pkt_go, wr_go, rd_go, cmp_go, fl_go;
  logic [Bits-1:0] key_mem [Words];
  logic [Bits-1:0] care_mem [Words];
  logic [ID_Width-1:0] dst_mem [Words];
  logic [Weight_Width-1:0] wt_mem [Words];
  logic [Words-1:0] vld, pending, rest, match;
  logic [Bits-1:0] search, smask;
  logic [AddressSize-1:0] sel;
  function automatic logic [AddressSize-1:0] lsb(input logic [Words-1:0] v);
    lsb = '0;
    for (int i = Words - 1; i >= 0; i--)
      if (v[i]) lsb = AddressSize'(i);
  endfunction
  assign idle      = state == IDLE;
  assign fire      = mode == 3'b011;
  assign cmd_ready = up & idle;
  assign pkt_ready = cmd_ready & fire;
  assign cmd_go    = cmd_ready & cmd_valid;
  assign pkt_go    = pkt_ready & pkt_valid;
  assign wr_go     = cmd_go & (mode == 3'b001);
  assign rd_go     = cmd_go & (mode == 3'b010);
  assign cmp_go    = cmd_go & (mode == 3'b100);
  assign fl_go     = cmd_go & (mode == 3'b101);
  assign search    = fire ? {pkt_id, {(Bits-ID_Width){1'b0}}} : key_in;
  assign smask     = fire ? ID_MASK : care_in;
  assign rest      = pending & (pending - Words'(1));
  assign sel       = lsb(pending);
  assign out_valid  = state == STREAM;
  assign out_addr   = out_valid ? sel : '0;
  assign out_dst    = out_valid ? dst_mem[sel] : '0;
  assign out_weight = out_valid ? wt_mem[sel] : '0;
  always_comb begin
    match = '0;
    for (int i = 0; i < Words; i++)
      match[i] = vld[i] & ~|((key_mem[i] ^ search) & care_mem[i] & smask);
  end
  always_comb begin
    state_nx = idle ? (pkt_go ? SEARCH : IDLE) :
               state == SEARCH ? (|pending ? STREAM : IDLE) :
               (state == STREAM && !(out_ready && rest == '0)) ? STREAM : IDLE;
  end
  // table contents are not reset; only the valid bits are
  always_ff @(posedge clk) begin
    if (wr_go) begin
      key_mem[addr]  <= key_in;
      care_mem[addr] <= care_in;
      dst_mem[addr]  <= dst_in;
      wt_mem[addr]   <= weight_in;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      up       <= 1'b0;
      vld      <= '0;
      pending  <= '0;
      rd_valid <= 1'b0;
      rd_key   <= '0;
      rd_care  <= '0;
      rd_vld   <= 1'b0;
      hit      <= 1'b0;
      hitline  <= '0;
      hit_addr <= '0;
    end else begin
      state    <= state_nx;
      up       <= 1'b1;
      rd_valid <= rd_go | cmp_go;
      if (fl_go) vld <= '0;
      else if (wr_go) vld[addr] <= vld_in;
      if (pkt_go) pending <= match;
      else if (out_valid && out_ready) pending <= rest;
      if (rd_go) begin
        rd_key  <= key_mem[addr];
        rd_care <= care_mem[addr];
        rd_vld  <= vld[addr];
      end
      if (cmp_go) begin
        hit      <= |match;
        hitline  <= match;
        hit_addr <= lsb(match);
      end
    end
  end
endmodule

// File: doc/route_tcam_mc.md
Name: route_tcam_mc

Overview:
- Parametrised successor to the single-lookup TCAM spike router.
- Holds Words ternary entries. Each entry has a key, a care-mask, a valid bit, and a payload {DstID, Weight}.
- Supports write/read/compare/flush commands, plus a FIRE mode. In FIRE, each incoming PacketID is matched against all entries and every hit's payload is streamed out, lowest address first, over a valid/ready handshake.
- Sits between the neuron fire source and the spike-delivery fabric.

Parameters:
- ID_Width, 4, PacketID/DstID width
- Bits, 8, stored key width; ID occupies key[Bits-1:Bits-ID_Width]
- Words, 16, entry count (power of 2)
- AddressSize, 4, log2(Words)
- Weight_Width, 4, payload weight width

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-high reset
- mode  in  3  000 IDLE, 001 WRITE, 010 READ, 011 FIRE, 100 COMPARE, 101 FLUSH; others treated as IDLE
- cmd_valid  in  1  command strobe for WRITE/READ/COMPARE/FLUSH
- cmd_ready  out  1  high when the FSM is in IDLE
- addr  in  AddressSize  entry address for WRITE/READ
- key_in  in  Bits  write key / compare key
- care_in  in  Bits  write care-mask (1 = bit compared) / compare search mask
- vld_in  in  1  valid bit written with the entry
- dst_in  in  ID_Width  payload DstID written
- weight_in  in  Weight_Width  payload weight written
- pkt_valid  in  1  PacketID offered (FIRE)
- pkt_ready  out  1  PacketID accepted
- pkt_id  in  ID_Width  PacketID
- out_valid  out  1  payload valid
- out_ready  in  1  downstream accepts payload
- out_dst  out  ID_Width  matched DstID
- out_weight  out  Weight_Width  matched weight
- out_addr  out  AddressSize  matched entry address
- rd_valid  out  1  READ/COMPARE result strobe, one cycle wide
- rd_key  out  Bits  read key
- rd_care  out  Bits  read care-mask
- rd_vld  out  1  read valid bit
- hit  out  1  COMPARE: any match
- hitline  out  Words  COMPARE match vector
- hit_addr  out  AddressSize  COMPARE lowest matching address

Behaviour:
- Reset (async): all outputs 0 except cmd_ready = 0 during reset and 1 from the first clk after reset deasserts. Valid bits are cleared; key/care/payload storage is not reset. FSM goes to IDLE.
- Entry match rule: vld[i] & ((key[i] ^ search) & care[i] & smask) == 0.
- FSM states: IDLE, SEARCH, STREAM.
- WRITE (IDLE, cmd_valid): entry addr is updated at that edge. FSM stays in IDLE.
- READ: rd_valid, rd_key, rd_care and rd_vld are presented the cycle after the command (1-cycle latency).
- COMPARE: search = key_in, smask = care_in. hit, hitline and hit_addr are registered with rd_valid one cycle later. Outputs hold until the next COMPARE or reset.
- FLUSH: clears all valid bits at that edge.
- Mode sampling: mode is sampled only in IDLE. Changing mode outside IDLE has no effect until the FSM returns to IDLE.
- FIRE, IDLE state: pkt_ready = 1. On pkt_valid & pkt_ready:
  - search = {pkt_id, zeros}; smask covers the ID bits only.
  - The match vector is registered into a pending register.
  - FSM goes to SEARCH.
- SEARCH (1 cycle):
  - pending == 0: back to IDLE; no output is produced.
  - Otherwise: go to STREAM.
- STREAM:
  - out_valid = 1. out_addr is the lowest set pending bit; out_dst/out_weight are that entry's payload.
  - Output is held stable while out_ready = 0.
  - On out_valid & out_ready: clear that pending bit. If the remaining vector is 0, go to IDLE; else present the next match in the following cycle (one result per cycle at full throughput).
- Peak latency: PacketID acceptance to first out_valid is 2 cycles.
- Blocking: cmd_ready = 0 and pkt_ready = 0 outside IDLE. Commands and packets are not queued.
- Table snapshot: writes cannot occur mid-stream, so the streamed payloads reflect the table as it was at PacketID acceptance.
- Reset mid-STREAM: out_valid drops immediately (async), pending is cleared, FSM returns to IDLE.
- Simultaneous cmd_valid and pkt_valid: resolved by mode; only the one matching the current mode acts.

Test Plan:
- Reset, then WRITE addr 3: key 0x50, care 0xF0, vld 1, dst 9, weight 5. FIRE pkt_id 5 -> out_valid 2 cycles later with out_addr 3, out_dst 9, out_weight 5, then IDLE.
- Three entries with ID 0xA at addrs 1, 7, 15; out_ready held 1 -> three consecutive beats with addr 1, 7, 15; pkt_ready high the cycle after the last beat.
- Same setup, out_ready toggling 0/1 -> each payload held stable while stalled; no beat lost or duplicated.
- FIRE pkt_id 0xC with no match -> no out_valid; pkt_ready returns 1 two cycles after acceptance.
- COMPARE key 0x5F, care 0xFF against entry addr 3 (care 0xF0) and addr 8 (key 0x5F, care 0xFF) -> hit 1, hitline 0x0108, hit_addr 3. FLUSH, then repeat -> hit 0, hitline 0.
- Assert rst during the second beat of a three-match stream -> out_valid 0 immediately; after release a READ of addr 1 gives rd_vld 0.
